// File: rtl/spi_mem_ctrl.sv
// rtl/spi_mem_ctrl.sv - single-request SPI SRAM read/write controller for the rv32e core
module spi_mem_ctrl #(
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic        phase, phase_nxt;
    logic [6:0]  cnt, cnt_nxt;
    logic [63:0] tx, tx_nxt;
    logic [31:0] rx, rx_nxt;
    logic        is_write, is_write_nxt;
    logic [1:0]  size, size_nxt;
    logic [6:0]  data_bits;

    logic        cs_n_d, sck_d, mosi_d, ready_d, valid_d;
    logic [31:0] rdata_d;

    // rx collects data bits in wire order; this reorders them little-endian
    function automatic logic [31:0] order_rx(input logic [31:0] r, input logic [1:0] s);
        case (s)
            2'd0:    return {24'h0, r[7:0]};
            2'd1:    return {16'h0, r[7:0], r[15:8]};
            default: return {r[7:0], r[15:8], r[23:16], r[31:24]};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 1'b0;
            cnt        <= 7'd0;
            tx         <= 64'h0;
            rx         <= 32'h0;
            is_write   <= 1'b0;
            size       <= 2'd0;
            spi_cs_n   <= 1'b1;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            cnt        <= cnt_nxt;
            tx         <= tx_nxt;
            rx         <= rx_nxt;
            is_write   <= is_write_nxt;
            size       <= size_nxt;
            spi_cs_n   <= cs_n_d;
            spi_sck    <= sck_d;
            spi_mosi   <= mosi_d;
            req_ready  <= ready_d;
            resp_valid <= valid_d;
            resp_rdata <= rdata_d;
        end
    end

    always_comb begin
        case (size)
            2'd0:    data_bits = 7'd8;
            2'd1:    data_bits = 7'd16;
            default: data_bits = 7'd32;
        endcase
    end

    // cnt holds the number of bits still to go after the current one
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        cnt_nxt      = cnt;
        tx_nxt       = tx;
        rx_nxt       = rx;
        is_write_nxt = is_write;
        size_nxt     = size;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt    = SHIFT;
                    phase_nxt    = 1'b0;
                    is_write_nxt = req_write;
                    rx_nxt       = 32'h0;
                    case (req_size)
                        2'd0: begin size_nxt = 2'd0; cnt_nxt = 7'd39; end
                        2'd1: begin size_nxt = 2'd1; cnt_nxt = 7'd47; end
                        default: begin size_nxt = 2'd2; cnt_nxt = 7'd63; end
                    endcase
                    tx_nxt = {req_write ? CMD_WRITE : CMD_READ, req_addr,
                              req_write ? {req_wdata[7:0], req_wdata[15:8],
                                           req_wdata[23:16], req_wdata[31:24]} : 32'h0};
                end
            end
            SHIFT: begin
                if (!phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (!is_write && cnt < data_bits)
                        rx_nxt = {rx[30:0], spi_miso};
                    if (cnt == 7'd0) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt - 7'd1;
                        tx_nxt  = {tx[62:0], 1'b0};
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode works on next-state values so every pin leaves a flop
    always_comb begin
        cs_n_d  = (state_nxt != SHIFT);
        sck_d   = (state_nxt == SHIFT) && phase_nxt;
        mosi_d  = (state_nxt == SHIFT) && tx_nxt[63];
        ready_d = (state_nxt == IDLE);
        valid_d = (state_nxt == DONE);
        rdata_d = resp_rdata;
        if (state_nxt == DONE)
            rdata_d = is_write ? 32'h0 : order_rx(rx_nxt, size);
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb/tb_spi_mem_ctrl.sv - directed bench for spi_mem_ctrl with SPI SRAM model and response scoreboard
module tb_spi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [23:0] req_addr = 24'h0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int          errors = 0;
    int          checks = 0;
    int          resp_seen = 0;
    int          rises = 0;
    int          idle_rises = 0;
    logic [79:0] mosi_bits = 80'h0;
    logic [31:0] mem_word = 32'h0;
    logic [31:0] exp_q[$];

    spi_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: byte i of mem_word is returned i-th; opcode/address bits drive 1 to prove they are ignored
    function automatic logic miso_bit(input int k);
        int d;
        if (k < 32) return 1'b1;
        d = k - 32;
        if (d >= 32) return 1'b1;
        return mem_word[8 * (d / 8) + 7 - (d % 8)];
    endfunction

    always @(negedge spi_cs_n) begin
        rises     = 0;
        mosi_bits = 80'h0;
    end

    always @(posedge spi_sck) begin
        if (!spi_cs_n) begin
            mosi_bits = {mosi_bits[78:0], spi_mosi};
            rises++;
        end else begin
            idle_rises++;
        end
    end

    always @(negedge spi_sck or negedge spi_cs_n) begin
        #1;
        spi_miso = miso_bit(rises);
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            resp_seen++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL resp_unexpected observed_pending=%0d expected_pending>=1", exp_q.size());
            end
            if (exp_q.size() > 0) check("resp_rdata", {48'h0, resp_rdata}, {48'h0, exp_q.pop_front()});
        end
    end

    // Drives a request at a falling edge and returns at the falling edge inside cycle 1
    task automatic send(input logic w, input logic [23:0] a, input logic [1:0] s,
                        input logic [31:0] wd, input logic [31:0] mem,
                        input logic [31:0] exp, input bit push, input bit hold);
        int n;
        @(negedge clk);
        mem_word  = mem;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_size  = s;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {79'h0, req_ready}, 80'h1);
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        check("cycle1_cs_n", {79'h0, spi_cs_n}, 80'h0);
        check("cycle1_mosi_op_bit7", {79'h0, spi_mosi}, {79'h0, w ? 1'b0 : 1'b0});
    endtask

    task automatic wait_resp(input int exp_cycle, input string tag);
        int c;
        c = 1;
        while (!resp_valid && c < 400) begin
            @(negedge clk);
            c++;
        end
        check(tag, 80'(c), 80'(exp_cycle));
    endtask

    initial begin
        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", {79'h0, spi_cs_n}, 80'h1);
        check("rst_sck", {79'h0, spi_sck}, 80'h0);
        check("rst_mosi", {79'h0, spi_mosi}, 80'h0);
        check("rst_ready", {79'h0, req_ready}, 80'h1);
        check("rst_resp_valid", {79'h0, resp_valid}, 80'h0);
        check("rst_rdata", {48'h0, resp_rdata}, 80'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_sck_quiet", 80'(idle_rises), 80'h0);
        check("idle_cs_n", {79'h0, spi_cs_n}, 80'h1);

        // Word read at 0x000100
        send(1'b0, 24'h000100, 2'd2, 32'h0, 32'h12345678, 32'h12345678, 1'b1, 1'b0);
        wait_resp(129, "word_read_cycle");
        @(negedge clk);
        check("word_read_hdr", {48'h0, mosi_bits[63:32]}, {48'h0, 32'h03000100});
        check("word_read_sck_rises", 80'(rises), 80'd64);

        // Half read at 0x00ABCD
        send(1'b0, 24'h00ABCD, 2'd1, 32'h0, 32'h1234BEEF, 32'h0000BEEF, 1'b1, 1'b0);
        wait_resp(97, "half_read_cycle");
        @(negedge clk);
        check("half_read_hdr", {48'h0, mosi_bits[47:16]}, {48'h0, 32'h0300ABCD});
        check("half_read_sck_rises", 80'(rises), 80'd48);

        // Byte write at 0x123456
        send(1'b1, 24'h123456, 2'd0, 32'hDEADBEA5, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        wait_resp(81, "byte_write_cycle");
        @(negedge clk);
        check("byte_write_mosi", {40'h0, mosi_bits[39:0]}, {40'h0, 40'h02123456A5});
        check("byte_write_sck_rises", 80'(rises), 80'd40);

        // Reset at cycle 40 of a word read; no response may follow
        send(1'b0, 24'h000300, 2'd3, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_cs_n", {79'h0, spi_cs_n}, 80'h1);
        check("abort_ready", {79'h0, req_ready}, 80'h1);
        check("abort_sck", {79'h0, spi_sck}, 80'h0);
        repeat (150) @(negedge clk);
        check("abort_no_resp", 80'(resp_seen), 80'd3);

        send(1'b0, 24'hFFFFFC, 2'd2, 32'h0, 32'hC4332211, 32'hC4332211, 1'b1, 1'b0);
        wait_resp(129, "post_abort_cycle");
        @(negedge clk);
        check("post_abort_hdr", {48'h0, mosi_bits[63:32]}, {48'h0, 32'h03FFFFFC});

        // Back-to-back word reads with req_valid held high
        send(1'b0, 24'h000200, 2'd2, 32'h0, 32'hDDCCBBAA, 32'hDDCCBBAA, 1'b1, 1'b1);
        wait_resp(129, "b2b_first_cycle");
        check("b2b_done_cs_n", {79'h0, spi_cs_n}, 80'h1);
        req_addr = 24'h000204;
        mem_word = 32'hFE7F8001;
        exp_q.push_back(32'hFE7F8001);
        @(negedge clk);
        check("b2b_accept_ready", {79'h0, req_ready}, 80'h1);
        check("b2b_accept_cs_n", {79'h0, spi_cs_n}, 80'h1);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_second_cs_low", {79'h0, spi_cs_n}, 80'h0);
        wait_resp(129, "b2b_second_cycle");
        @(negedge clk);
        check("b2b_second_hdr", {48'h0, mosi_bits[63:32]}, {48'h0, 32'h03000204});

        repeat (4) @(negedge clk);
        check("resp_total", 80'(resp_seen), 80'd6);
        check("scoreboard_empty", 80'(exp_q.size()), 80'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
